// File: rtl/ifetch_unit_if.sv
// Fetch-side bus bundle: instruction-ROM request/ack channel plus the decode hand-off.
//   irom: irom_req/irom_addr held stable until the cycle irom_ack is seen high (rdata valid then);
//   decode: inst_valid/inst hold until id_ready is seen high; a transfer happens when both are 1.
interface ifetch_unit_if;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_ack;
    logic [31:0] irom_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        id_ready;

    modport master (
        output irom_req, irom_addr, inst, inst_valid,
        input  irom_ack, irom_rdata, id_ready
    );

    modport slave (
        input  irom_req, irom_addr, inst, inst_valid,
        output irom_ack, irom_rdata, id_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over irom req/ack, hands words to decode.
// Optional macro IFETCH_PERF_EN adds perf_fetch_cnt / perf_wait_cnt counters.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic [31:0]   npc,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   pc,
    output logic [1:0]    dbg_state,
    ifetch_unit_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic [31:0] inst, inst_n;
    logic        inst_valid, inst_valid_n;
    logic        irom_req, irom_req_n;

    assign bus.irom_req   = irom_req;
    assign bus.irom_addr  = pc;
    assign bus.inst       = inst;
    assign bus.inst_valid = inst_valid;
    assign dbg_state      = state;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            pend_pc    <= 32'h0;
            inst       <= 32'h0;
            inst_valid <= 1'b0;
            irom_req   <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend_pc    <= pend_pc_n;
            inst       <= inst_n;
            inst_valid <= inst_valid_n;
            irom_req   <= irom_req_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_pc_n    = pend_pc;
        inst_n       = inst;
        inst_valid_n = inst_valid;
        irom_req_n   = irom_req;
        case (state)
            S_IDLE: begin
                if (redirect) pc_n = redirect_pc;
                inst_valid_n = 1'b0;
                irom_req_n   = 1'b1;
                state_n      = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    // An acked request is already finished, so the redirect can take effect now.
                    if (bus.irom_ack) begin
                        pc_n = redirect_pc;
                    end else begin
                        pend_pc_n = redirect_pc;
                        state_n   = S_DRAIN;
                    end
                end else if (bus.irom_ack) begin
                    inst_n       = bus.irom_rdata;
                    inst_valid_n = 1'b1;
                    irom_req_n   = 1'b0;
                    state_n      = S_VALID;
                end
            end
            S_VALID: begin
                if (redirect) begin
                    pc_n         = redirect_pc;
                    inst_valid_n = 1'b0;
                    irom_req_n   = 1'b1;
                    state_n      = S_REQ;
                end else if (bus.id_ready) begin
                    pc_n         = npc;
                    inst_valid_n = 1'b0;
                    irom_req_n   = 1'b1;
                    state_n      = S_REQ;
                end
            end
            S_DRAIN: begin
                // The outstanding request stays untouched; its returned data is thrown away.
                if (redirect) pend_pc_n = redirect_pc;
                if (bus.irom_ack) begin
                    pc_n    = redirect ? redirect_pc : pend_pc;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_wait_cnt  <= 32'h0;
        end else begin
            if (state == S_VALID && bus.id_ready && !redirect)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state == S_REQ || state == S_DRAIN) && !bus.irom_ack)
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: hand-computed vectors plus an expected-instruction queue.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_VALID = 2'd2, ST_DRAIN = 2'd3;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] npc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [1:0]  dbg_state;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;
`endif

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(RST_PC)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .npc         (npc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .dbg_state   (dbg_state),
        .bus         (bus)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    // clock / reset
    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] next_pc);
        npc = next_pc;
        bus.id_ready = 1'b1;
        if (exp_q.size() > 0) check("sb_inst", bus.inst, exp_q.pop_front());
        else check("sb_empty", bus.inst_valid, 1'b0);
        step();
        bus.id_ready = 1'b0;
    endtask

    task automatic mem_ack(input logic [31:0] data);
        bus.irom_ack   = 1'b1;
        bus.irom_rdata = data;
        step();
        bus.irom_ack   = 1'b0;
        bus.irom_rdata = 32'h0;
    endtask

    initial begin
        cpu_rst        = 1'b1;
        npc            = 32'h0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        bus.irom_ack   = 1'b0;
        bus.irom_rdata = 32'h0;
        bus.id_ready   = 1'b0;
        step();
        step();
        check("rst_req",   {31'b0, bus.irom_req}, 32'd0);
        check("rst_pc",    pc, RST_PC);
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst",  bus.inst, 32'h0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});

        // first fetch, immediate ack
        cpu_rst = 1'b0;
        step();
        check("f1_req",  {31'b0, bus.irom_req}, 32'd1);
        check("f1_addr", bus.irom_addr, 32'h1c00_0000);
        exp_q.push_back(32'h0280_0421);
        mem_ack(32'h0280_0421);
        check("f1_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("f1_inst",  bus.inst, 32'h0280_0421);
        check("f1_req_lo", {31'b0, bus.irom_req}, 32'd0);

        // accept loads npc
        accept(32'h1c00_0004);
        check("acc_pc",    pc, 32'h1c00_0004);
        check("acc_req",   {31'b0, bus.irom_req}, 32'd1);
        check("acc_valid", {31'b0, bus.inst_valid}, 32'd0);

        // ack delayed 3 cycles
        for (int i = 0; i < 3; i++) begin
            check("dly_req",   {31'b0, bus.irom_req}, 32'd1);
            check("dly_addr",  bus.irom_addr, 32'h1c00_0004);
            check("dly_valid", {31'b0, bus.inst_valid}, 32'd0);
            step();
        end
`ifdef IFETCH_PERF_EN
        check("perf_wait", perf_wait_cnt, 32'd3);
`endif
        exp_q.push_back(32'h0010_0013);
        mem_ack(32'h0010_0013);
        check("dly_valid_hi", {31'b0, bus.inst_valid}, 32'd1);
        check("dly_inst",     bus.inst, 32'h0010_0013);

        // decode stall for 5 cycles, npc must not be loaded
        npc = 32'h1c00_0008;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stl_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("stl_inst",  bus.inst, 32'h0010_0013);
            check("stl_pc",    pc, 32'h1c00_0004);
            check("stl_req",   {31'b0, bus.irom_req}, 32'd0);
        end
        accept(32'h1c00_0008);
        check("acc2_pc", pc, 32'h1c00_0008);
`ifdef IFETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 32'd2);
`endif

        // redirect during an outstanding request -> drain
        redirect    = 1'b1;
        redirect_pc = 32'h0000_8000;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("drn_state", {30'b0, dbg_state}, {30'b0, ST_DRAIN});
            check("drn_addr",  bus.irom_addr, 32'h1c00_0008);
            check("drn_req",   {31'b0, bus.irom_req}, 32'd1);
            check("drn_valid", {31'b0, bus.inst_valid}, 32'd0);
            if (i == 0) step();
        end
        mem_ack(32'hdead_beef);
        check("drn_pc",    pc, 32'h0000_8000);
        check("drn_addr2", bus.irom_addr, 32'h0000_8000);
        check("drn_req2",  {31'b0, bus.irom_req}, 32'd1);
        check("drn_valid2", {31'b0, bus.inst_valid}, 32'd0);
        check("drn_inst",  bus.inst, 32'h0010_0013);
        exp_q.push_back(32'h1234_5678);
        mem_ack(32'h1234_5678);
        check("rd_inst", bus.inst, 32'h1234_5678);

        // redirect beats id_ready in S_VALID
        npc          = 32'h0000_0010;
        redirect_pc  = 32'h0000_0200;
        redirect     = 1'b1;
        bus.id_ready = 1'b1;
        step();
        redirect     = 1'b0;
        bus.id_ready = 1'b0;
        void'(exp_q.pop_front());
        check("rv_pc",    pc, 32'h0000_0200);
        check("rv_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rv_state", {30'b0, dbg_state}, {30'b0, ST_REQ});
`ifdef IFETCH_PERF_EN
        check("rv_perf_fetch", perf_fetch_cnt, 32'd2);
`endif

        // redirect coincident with ack in S_REQ: data dropped, stay in S_REQ
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        mem_ack(32'hbad0_bad0);
        redirect = 1'b0;
        check("ra_pc",    pc, 32'h0000_0300);
        check("ra_state", {30'b0, dbg_state}, {30'b0, ST_REQ});
        check("ra_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("ra_req",   {31'b0, bus.irom_req}, 32'd1);

        // reset mid-request
        cpu_rst = 1'b1;
        step();
        cpu_rst = 1'b0;
        check("mr_req",   {31'b0, bus.irom_req}, 32'd0);
        check("mr_pc",    pc, RST_PC);
        check("mr_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});

        // two redirects while draining: the latest target wins
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        step();
        redirect_pc = 32'h0000_0500;
        step();
        redirect = 1'b0;
        check("lw_addr", bus.irom_addr, RST_PC);
        mem_ack(32'h0bad_0bad);
        check("lw_pc",    pc, 32'h0000_0500);
        check("lw_state", {30'b0, dbg_state}, {30'b0, ST_REQ});
        check("lw_valid", {31'b0, bus.inst_valid}, 32'd0);

        // final report
        check("sb_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Sequential consumer of the next-PC value: holds the architectural PC, fetches instructions over a req/ack handshake to instruction ROM, and presents them to decode.
- Its `pc` output drives the NPC generator. When decode accepts an instruction, the unit loads the returned `npc`.
- Sits between the NPC logic, the instruction memory and the decode stage of the multi-cycle core.
- Supports variable memory latency and an exception/flush redirect that can arrive mid-request.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- cpu_clk  in  1  system clock; all state updates on rising edge
- cpu_rst  in  1  synchronous reset, active-high
- npc  in  32  next PC from the NPC generator (combinational function of `pc`)
- redirect  in  1  flush request; overrides normal sequencing
- redirect_pc  in  32  target PC for the redirect
- irom_req  out  1  fetch request to instruction memory
- irom_addr  out  32  fetch address; always equals `pc`
- irom_ack  in  1  memory completes the request this cycle
- irom_rdata  in  32  instruction word, valid when `irom_ack`=1
- pc  out  32  current PC, to NPC and decode
- inst  out  32  fetched instruction
- inst_valid  out  1  `inst` is valid for decode
- id_ready  in  1  decode accepts `inst` this cycle

Behaviour:
- Reset and clocking:
  - One clock, `cpu_clk`. Reset is synchronous and active-high on `cpu_rst`, sampled at the rising edge.
  - Reset values: state=S_IDLE, pc=RESET_PC, inst=0, inst_valid=0, irom_req=0, pend_pc=0.
  - `cpu_rst` has priority over all other inputs. Reset mid-request abandons the transaction: req drops next cycle and the memory side must tolerate this.
- All outputs are registered. `irom_addr` is a continuous copy of `pc`.
- States: S_IDLE, S_REQ, S_VALID, S_DRAIN.
- S_IDLE: next edge -> S_REQ with irom_req<=1 (first request one cycle after reset release).
- S_REQ:
  - irom_req=1, addr stable.
  - On irom_ack: inst<=irom_rdata, inst_valid<=1, irom_req<=0 -> S_VALID.
  - Without ack: hold.
- S_VALID:
  - inst_valid=1, inst held stable.
  - On id_ready: pc<=npc, inst_valid<=0, irom_req<=1 -> S_REQ.
  - Otherwise hold indefinitely (stall).
- S_DRAIN:
  - irom_req=1 and addr unchanged, because the outstanding request must not be altered.
  - On irom_ack: data discarded, pc<=pend_pc, irom_req stays 1 -> S_REQ.
- Redirect (priority over ack/id_ready, below reset):
  - S_IDLE or S_VALID: pc<=redirect_pc, inst_valid<=0, irom_req<=1 -> S_REQ. A coincident id_ready is ignored and npc is not loaded.
  - S_REQ with irom_ack same cycle: transaction is complete. Data dropped, pc<=redirect_pc, irom_req stays 1, stay S_REQ.
  - S_REQ without ack: pend_pc<=redirect_pc -> S_DRAIN.
  - S_DRAIN: pend_pc<=redirect_pc (latest wins). If coincident with ack, pc<=redirect_pc directly -> S_REQ.
- Latency and throughput:
  - Minimum 2 cycles per instruction (one S_REQ cycle with immediate ack, plus one S_VALID cycle with id_ready).
  - Fetch latency = memory ack latency + 1.
- Arithmetic and data rules:
  - PC is 32-bit with no alignment enforcement. npc/redirect_pc are loaded verbatim.
  - PC wrap-around is the NPC's concern and passes through unchanged.
- inst_valid is never asserted in S_REQ/S_DRAIN. Data from a flushed transaction never appears on `inst`.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- Enabled:
  - Adds outputs perf_fetch_cnt[31:0] and perf_wait_cnt[31:0], both reset to 0 and wrapping modulo 2^32.
  - perf_fetch_cnt increments on each accepted instruction (S_VALID && id_ready && !redirect).
  - perf_wait_cnt increments on every cycle in S_REQ or S_DRAIN with irom_ack=0.
- Disabled: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h1c00_0000, release -> irom_req=0 in the first cycle, then 1 with irom_addr=32'h1c00_0000; irom_ack immediate with rdata=32'h0280_0421 -> next cycle inst_valid=1, inst=32'h0280_0421.
- Accept with id_ready=1 while npc=32'h1c00_0004 -> next cycle pc=32'h1c00_0004, irom_req=1, inst_valid=0.
- Memory ack delayed 3 cycles -> irom_req and irom_addr stable for 3 cycles, inst_valid rises the cycle after ack; with IFETCH_PERF_EN, perf_wait_cnt=3.
- id_ready=0 for 5 cycles in S_VALID -> inst/inst_valid/pc held, irom_req=0, no npc load.
- redirect to 32'h0000_8000 during S_REQ, ack 2 cycles later with 32'hDEAD_BEEF -> addr unchanged until ack, DEAD_BEEF never valid, next request at 32'h0000_8000.
- redirect and id_ready together in S_VALID (npc=32'h10, redirect_pc=32'h200) -> pc=32'h200; cpu_rst asserted mid-request -> next cycle irom_req=0, pc=RESET_PC.
